// File: rtl/delta_adc_pkg.sv
// Shared definitions for the delta conversion path (tracking ADC and PWM DAC).
// Holds the default data/period width, the default strobe length and the
// period-counter state encoding used by both sides.
package delta_adc_pkg;

  localparam int unsigned DefaultW            = 16;
  localparam int unsigned DefaultStrobeCycles = 16;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } pwm_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter shared by the delta ADC and DAC.
// Owns the IDLE/RUN state, the running count and the latched period.
//   clk_i     : clock, rising edge
//   reset_i   : synchronous active-high reset
//   period_i  : requested period P in cycles, sampled only at start / period end; 0 = stop
//   run_o     : counter is in RUN
//   cnt_o     : position within the current period, 0..P_lat-1
//   start_o   : this cycle leaves IDLE (first cycle with period_i != 0)
//   reload_o  : a new period begins at the next edge (start or non-stopping period end)
module pwm_period_counter
  import delta_adc_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] period_i,
  output logic         run_o,
  output logic [W-1:0] cnt_o,
  output logic         start_o,
  output logic         reload_o
);

  pwm_state_e   state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] p_lat_q;
  logic         boundary;
  logic         period_nz;

  assign period_nz = (period_i != '0);
  // In RUN p_lat_q is never 0, so the subtraction cannot wrap.
  assign boundary  = (state_q == StRun) && (cnt_q == p_lat_q - 1'b1);
  assign start_o   = (state_q == StIdle) && period_nz;
  assign reload_o  = start_o | (boundary & period_nz);
  assign run_o     = (state_q == StRun);
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_lat_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (period_nz) begin
            state_q <= StRun;
            p_lat_q <= period_i;
          end
        end
        StRun: begin
          if (boundary) begin
            // Period programming only takes effect here, never mid-period.
            p_lat_q <= period_i;
            cnt_q   <= '0;
            if (!period_nz) state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/delta_pwm_dac.sv
// PWM DAC: output end of the delta conversion path.
// Buffers one duty sample behind a valid/ready handshake, moves it into the
// active duty register at each period start and drives a registered PWM
// waveform plus a period strobe aligned with it.
//   clk                : clock, rising edge
//   reset              : synchronous active-high reset
//   Period_counter_val : PWM period in cycles, latched at period boundaries; 0 = stop
//   Sample_i           : duty value (high cycles per period)
//   Sample_valid_i     : Sample_i valid
//   Sample_ready_o     : holding register empty
//   PWM_O              : registered PWM output
//   Period_strb_o      : high for min(STROBE_CYCLES, P) cycles from period start
//   Underrun_o         : sticky, a period started without a fresh sample
module delta_pwm_dac
  import delta_adc_pkg::*;
#(
  parameter int unsigned W             = DefaultW,
  parameter int unsigned STROBE_CYCLES = DefaultStrobeCycles
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] Period_counter_val,
  input  logic [W-1:0] Sample_i,
  input  logic         Sample_valid_i,
  output logic         Sample_ready_o,
  output logic         PWM_O,
  output logic         Period_strb_o,
  output logic         Underrun_o
);

  localparam logic [W:0] StrobeLim = (W+1)'(STROBE_CYCLES);

  logic         run;
  logic [W-1:0] cnt;
  logic         start;
  logic         reload;

  logic [W-1:0] hold_q, hold_d;
  logic         full_q, full_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;
  logic         strb_q, strb_d;
  logic         under_q, under_d;
  logic         accept;

  pwm_period_counter #(
    .W (W)
  ) u_counter (
    .clk_i    (clk),
    .reset_i  (reset),
    .period_i (Period_counter_val),
    .run_o    (run),
    .cnt_o    (cnt),
    .start_o  (start),
    .reload_o (reload)
  );

  assign Sample_ready_o = ~full_q & ~reset;
  assign accept         = Sample_valid_i & Sample_ready_o;

  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    duty_d  = duty_q;
    under_d = under_q;

    if (reload) begin
      if (full_q) begin
        duty_d = hold_q;
        full_d = 1'b0;
      end else if (start) begin
        // Leaving IDLE with nothing buffered starts from a silent output.
        duty_d = '0;
      end
    end

    // Cannot collide with the transfer above: accept needs full_q == 0.
    if (accept) begin
      hold_d = Sample_i;
      full_d = 1'b1;
    end

    // Set takes priority over the clear from a same-cycle accept.
    if (reload && !start && !full_q) begin
      under_d = 1'b1;
    end else if (accept) begin
      under_d = 1'b0;
    end

    pwm_d  = run & (cnt < duty_q);
    strb_d = run & ({1'b0, cnt} < StrobeLim);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      full_q  <= 1'b0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      strb_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      full_q  <= full_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      strb_q  <= strb_d;
      under_q <= under_d;
    end
  end

  assign PWM_O         = pwm_q;
  assign Period_strb_o = strb_q;
  assign Underrun_o    = under_q;

endmodule

// File: tb/tb_delta_pwm_dac.sv
module tb_delta_pwm_dac;

  localparam int W  = 16;
  localparam int SC = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pcv;
  logic [W-1:0] smp;
  logic         valid;
  logic         ready;
  logic         pwm;
  logic         strb;
  logic         under;

  always #5 clk = ~clk;

  delta_pwm_dac #(
    .W             (W),
    .STROBE_CYCLES (SC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .Period_counter_val (pcv),
    .Sample_i           (smp),
    .Sample_valid_i     (valid),
    .Sample_ready_o     (ready),
    .PWM_O              (pwm),
    .Period_strb_o      (strb),
    .Underrun_o         (under)
  );

  typedef struct packed {
    logic pwm;
    logic strb;
    logic under;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a period is "len" cycles long; pos is the cycle within it.
  // Output in the cycle after position pos: high while pos < duty, strobe while pos < SC.
  bit   m_run   = 0;
  int   m_pos   = 0;
  int   m_len   = 0;
  int   m_duty  = 0;
  bit   m_under = 0;
  int   m_hold[$];
  bit   started = 0;

  int   p_in, s_in;
  bit   acc_m, set_u;
  exp_t e;

  always @(posedge clk) begin
    p_in = int'(pcv);
    s_in = int'(smp);
    if (reset) begin
      m_run = 0; m_pos = 0; m_len = 0; m_duty = 0; m_under = 0;
      m_hold.delete();
      e = '0;
    end else begin
      e.pwm  = m_run && (m_pos < m_duty);
      e.strb = m_run && (m_pos < SC);
      acc_m  = valid && (m_hold.size() == 0);
      set_u  = 0;
      if (!m_run) begin
        if (p_in != 0) begin
          m_run  = 1;
          m_len  = p_in;
          m_pos  = 0;
          m_duty = (m_hold.size() != 0) ? m_hold.pop_front() : 0;
        end
      end else if (m_pos == m_len - 1) begin
        m_len = p_in;
        m_pos = 0;
        if (p_in == 0) m_run = 0;
        else if (m_hold.size() != 0) m_duty = m_hold.pop_front();
        else set_u = 1;
      end else begin
        m_pos++;
      end
      if (acc_m) m_hold.push_back(s_in);
      if (set_u) m_under = 1;
      else if (acc_m) m_under = 0;
      e.under = m_under;
    end
    exp_q.push_back(e);
    started = 1;
  end

  task automatic chk(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a new output word every cycle.
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty at %0t: actual=empty required=entry", $time);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("pwm", pwm, x.pwm);
        chk("strobe", strb, x.strb);
        chk("underrun", under, x.under);
        chk("ready", ready, !reset && (m_hold.size() == 0));
      end
    end
  end

  task automatic step(input int p, input int s, input bit v, input bit r);
    pcv = W'(p); smp = W'(s); valid = v; reset = r;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample until accepted, bounded.
  task automatic send(input int p, input int s);
    bit acc;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      pcv = W'(p); smp = W'(s); valid = 1'b1; reset = 1'b0;
      #1;
      acc = ready;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout at %0t: actual=not_accepted required=accepted", $time);
    end
  endtask

  task automatic idle(input int p, input int n);
    for (int i = 0; i < n; i++) step(p, 0, 0, 0);
  endtask

  int rp;

  initial begin
    repeat (3) step(0, 0, 0, 1);
    // Sample buffered in IDLE, then P=10.
    send(0, 3);
    idle(10, 36);
    // Back-to-back 3 then 7; 7 waits for the boundary, then underrun, then clear.
    send(10, 3);
    send(10, 7);
    idle(10, 30);
    send(10, 5);
    idle(10, 12);
    // Duty edges with P=8.
    send(8, 0);  idle(8, 20);
    send(8, 8);  idle(8, 20);
    send(8, 20); idle(8, 20);
    // Period change mid-period, then stop.
    send(10, 4);
    idle(10, 7);
    idle(4, 20);
    idle(0, 15);
    // Reset mid-period with holding full.
    send(10, 4);
    idle(10, 3);
    send(10, 6);
    idle(10, 2);
    step(10, 0, 0, 1);
    idle(10, 25);
    // P=1 with valid held high and alternating samples.
    for (int i = 0; i < 40; i++) step(1, i & 1, 1, 0);
    idle(0, 5);
    // Randomised traffic.
    rp = 6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rp = $urandom_range(0, 12);
      step(rp, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 299) == 0));
    end
    idle(0, 5);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
